// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM state encoding for the multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Multiply: acc = {partial, multiplier}; opnd = multiplicand.
// Divide:   acc = {remainder, dividend/quotient}; opnd = divisor.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc_in,
   input  logic [WIDTH-1:0]     opnd,
   output logic [2*WIDTH-1:0]   acc_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             fits;

   // Both candidate steps are formed every cycle; is_div picks one.
   always_comb begin
      sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
      rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
      // True difference is below 2^WIDTH whenever it is used, so WIDTH bits suffice.
      diff   = rem_sh[WIDTH-1:0] - opnd;
      fits   = (rem_sh >= {1'b0, opnd});
      if (is_div) begin
         if (fits)
            acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
         else
            acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end else begin
         acc_out = {sum, acc_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: iterative signed/unsigned mul/div plus MTHI/MTLO.
// state   | meaning
// IDLE    | accepts start; MT ops complete here
// RUN     | one shift-add / restore step per cycle, counter 0..WIDTH-1
// FIX     | sign correction, HI/LO write, done pulse
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int FAST_MUL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             kill,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t                 state;
   logic [2*WIDTH-1:0]     acc;
   logic [2*WIDTH-1:0]     acc_next;
   logic [WIDTH-1:0]       opnd;
   logic [CW-1:0]          cnt;
   logic                   is_div;
   logic                   neg_q;
   logic                   neg_r;
   logic                   b_zero;

   logic                   op_signed;
   logic                   op_is_div;
   logic                   neg_a;
   logic                   neg_b;
   logic [WIDTH-1:0]       mag_a;
   logic [WIDTH-1:0]       mag_b;
   logic [2*WIDTH-1:0]     prod_fast;
   logic [2*WIDTH-1:0]     prod_fix;
   logic [WIDTH-1:0]       quo_fix;
   logic [WIDTH-1:0]       rem_fix;

   // Operand magnitudes and result signs for the op being issued.
   always_comb begin
      op_signed = ~op[0];
      op_is_div = op[1];
      neg_a     = op_signed & a[WIDTH-1];
      neg_b     = op_signed & b[WIDTH-1];
      mag_a     = neg_a ? -a : a;
      mag_b     = neg_b ? -b : b;
      prod_fast = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
   end

   // Sign-corrected results from the finished accumulator.
   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      // Divide by zero leaves the dividend as remainder; quotient is forced to all ones.
      if (b_zero) quo_fix = '1;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .acc_in  (acc),
      .opnd    (opnd),
      .acc_out (acc_next)
   );

   // Control FSM with registered busy/done/flag and HI/LO state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         hi          <= '0;
         lo          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         acc         <= '0;
         opnd        <= '0;
         cnt         <= '0;
         is_div      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         b_zero      <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !kill) begin
                  case (op)
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op_is_div;
                        neg_q  <= neg_a ^ neg_b;
                        neg_r  <= neg_a;
                        b_zero <= op_is_div && (b == '0);
                        if (FAST_MUL != 0 && !op_is_div) begin
                           acc   <= prod_fast;
                           state <= ST_FIX;
                        end else begin
                           acc   <= op_is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                           opnd  <= op_is_div ? mag_b : mag_a;
                           state <= ST_RUN;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               if (kill) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) state <= ST_FIX;
               end
            end
            ST_FIX: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
               if (!kill) begin
                  done        <= 1'b1;
                  div_by_zero <= b_zero;
                  if (is_div) begin
                     lo <= quo_fix;
                     hi <= rem_fix;
                  end else begin
                     lo <= prod_fix[WIDTH-1:0];
                     hi <= prod_fix[2*WIDTH-1:WIDTH];
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
